// File: rtl/downsampler.sv
// Symbol-phase tracking decimator for a zero-stuffed stream: locks on the first non-zero
// sample, re-aligns on off-phase energy, drops lock after IDLE_SYMS silent symbol slots.
// Optional off-phase event counter is built when DOWNSAMPLER_ERRCNT_EN is defined.
module downsampler #(
  parameter int WIDTH     = 4,
  parameter int FACTOR    = 16,
  parameter int IDLE_SYMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  output logic [WIDTH-1:0] symbol_out,
  output logic             symbol_valid,
  output logic             locked,
  output logic             realign,
  output logic [7:0]       err_count
);

  localparam int CNT_W  = (FACTOR > 2) ? $clog2(FACTOR) : 1;
  localparam int IDLE_W = $clog2(IDLE_SYMS + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FACTOR - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_SYMS);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDLE_W-1:0] idle_q;
  logic [WIDTH-1:0]  symbol_q;
  logic              valid_q;
  logic              locked_q;
  logic              realign_q;

  logic              sample_nz;
  logic              off_phase_hit;
  logic [IDLE_W-1:0] idle_inc;
  logic [CNT_W-1:0]  cnt_adv;

  assign sample_nz     = |sample_in;
  assign off_phase_hit = (state_q == ST_LOCKED) && (cnt_q != '0) && sample_nz;
  assign idle_inc      = idle_q + IDLE_ONE;
  assign cnt_adv       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_SEARCH;
      cnt_q     <= '0;
      idle_q    <= '0;
      symbol_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      realign_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      realign_q <= 1'b0;
      case (state_q)
        ST_SEARCH: begin
          locked_q <= sample_nz;
          if (sample_nz) begin
            symbol_q <= sample_in;
            valid_q  <= 1'b1;
            cnt_q    <= CNT_ONE;
            idle_q   <= '0;
            state_q  <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // locked stays high through the dropping strobe and falls one cycle later
          locked_q <= 1'b1;
          if (off_phase_hit) begin
            symbol_q  <= sample_in;
            valid_q   <= 1'b1;
            realign_q <= 1'b1;
            cnt_q     <= CNT_ONE;
            idle_q    <= '0;
          end else if (cnt_q == '0) begin
            symbol_q <= sample_in;
            valid_q  <= 1'b1;
            cnt_q    <= CNT_ONE;
            if (sample_nz) begin
              idle_q <= '0;
            end else if (idle_inc == IDLE_LIMIT) begin
              idle_q  <= '0;
              cnt_q   <= '0;
              state_q <= ST_SEARCH;
            end else begin
              idle_q <= idle_inc;
            end
          end else begin
            cnt_q <= cnt_adv;
          end
        end
        default: state_q <= ST_SEARCH;
      endcase
    end
  end

  assign symbol_out   = symbol_q;
  assign symbol_valid = valid_q;
  assign locked       = locked_q;
  assign realign      = realign_q;

`ifdef DOWNSAMPLER_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (off_phase_hit && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_downsampler.sv
// Scoreboard bench for downsampler: a time-based reference model pushes expected strobes
// and per-cycle status; an independent monitor pops and compares after each clock edge.
module tb_downsampler;

  localparam int WIDTH     = 4;
  localparam int FACTOR    = 16;
  localparam int IDLE_SYMS = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] sample_in = '0;
  logic [WIDTH-1:0] symbol_out;
  logic             symbol_valid;
  logic             locked;
  logic             realign;
  logic [7:0]       err_count;

  downsampler #(
    .WIDTH    (WIDTH),
    .FACTOR   (FACTOR),
    .IDLE_SYMS(IDLE_SYMS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .symbol_out  (symbol_out),
    .symbol_valid(symbol_valid),
    .locked      (locked),
    .realign     (realign),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    int               edge_no;
    logic [WIDTH-1:0] sym;
    logic             ra;
  } strobe_t;

  typedef struct {
    logic             lk;
    logic [7:0]       err;
    logic [WIDTH-1:0] sym;
  } status_t;

  strobe_t st_q[$];
  status_t cy_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Reference model: lock state, time of last captured symbol, run of silent symbol slots.
  bit               m_locked;
  int               m_last;
  int               m_zero_run;
  int               m_err;
  logic [WIDTH-1:0] m_sym;

  function void model_reset();
    m_locked   = 1'b0;
    m_last     = 0;
    m_zero_run = 0;
    m_err      = 0;
    m_sym      = '0;
  endfunction

  function logic [7:0] exp_err();
`ifdef DOWNSAMPLER_ERRCNT_EN
    return (m_err > 255) ? 8'd255 : 8'(m_err);
`else
    return 8'd0;
`endif
  endfunction

  function void model_step(input int e, input logic [WIDTH-1:0] s, input bit r);
    bit was;
    bit strobe;
    bit ra;
    status_t st;
    was    = m_locked;
    strobe = 1'b0;
    ra     = 1'b0;
    if (r) begin
      model_reset();
      st = '{1'b0, 8'd0, '0};
      cy_q.push_back(st);
      return;
    end
    if (!m_locked) begin
      if (s != 0) begin
        strobe     = 1'b1;
        m_locked   = 1'b1;
        m_zero_run = 0;
      end
    end else if (((e - m_last) % FACTOR) == 0) begin
      strobe     = 1'b1;
      m_zero_run = (s == 0) ? m_zero_run + 1 : 0;
      if (m_zero_run == IDLE_SYMS) m_locked = 1'b0;
    end else if (s != 0) begin
      strobe     = 1'b1;
      ra         = 1'b1;
      m_zero_run = 0;
      m_err++;
    end
    if (strobe) begin
      m_last = e;
      m_sym  = s;
      st_q.push_back('{e, s, ra});
    end
    st = '{(was || m_locked), exp_err(), m_sym};
    cy_q.push_back(st);
  endfunction

  // Monitor: strobes are matched against the strobe queue, status against the cycle queue.
  initial begin
    strobe_t exp_s;
    status_t exp_c;
    forever begin
      @(posedge clk);
      #1;
      while (st_q.size() > 0 && st_q[0].edge_no < edge_cnt) begin
        exp_s = st_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missing_strobe at edge %0d: expected symbol %0h was not observed", exp_s.edge_no, exp_s.sym);
      end
      if (symbol_valid === 1'b1) begin
        if (st_q.size() == 0) begin
          check("spurious_strobe", 32'(symbol_valid), 32'd0);
        end else begin
          exp_s = st_q.pop_front();
          check("strobe_edge", 32'(edge_cnt), 32'(exp_s.edge_no));
          check("strobe_symbol", 32'(symbol_out), 32'(exp_s.sym));
          check("strobe_realign", 32'(realign), 32'(exp_s.ra));
        end
      end else if (realign !== 1'b0) begin
        check("realign_without_strobe", 32'(realign), 32'd0);
      end
      if (cy_q.size() > 0) begin
        exp_c = cy_q.pop_front();
        check("locked", 32'(locked), 32'(exp_c.lk));
        check("err_count", 32'(err_count), 32'(exp_c.err));
        check("symbol_hold", 32'(symbol_out), 32'(exp_c.sym));
      end
    end
  end

  task automatic step(input logic [WIDTH-1:0] s, input bit r);
    @(negedge clk);
    sample_in = s;
    rst       = r;
    model_step(edge_cnt + 1, s, r);
  endtask

  task automatic send_symbol(input logic [WIDTH-1:0] s);
    step(s, 1'b0);
    repeat (FACTOR - 1) step('0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] acq_syms[5];
    logic [WIDTH-1:0] s;
    int               gen_phase;
    int               silent_left;
    int               r;

    model_reset();
    acq_syms = '{4'h9, 4'h3, 4'hD, 4'h0, 4'h7};

    // reset then idle
    repeat (10) step('0, 1'b1);
    repeat (40) step('0, 1'b0);

    // acquire and track
    foreach (acq_syms[i]) send_symbol(acq_syms[i]);

    // off-phase symbol at cnt=5
    step(4'h2, 1'b0);
    repeat (4) step('0, 1'b0);
    send_symbol(4'hA);
    send_symbol(4'h6);

    // lock loss on silence
    repeat (FACTOR * 6) step('0, 1'b0);

    // asynchronous reset mid-symbol at cnt=7
    step(4'h1, 1'b0);
    repeat (6) step('0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_symbol", 32'(symbol_out), 32'd0);
    check("async_rst_valid", 32'(symbol_valid), 32'd0);
    check("async_rst_locked", 32'(locked), 32'd0);
    check("async_rst_realign", 32'(realign), 32'd0);
    check("async_rst_err", 32'(err_count), 32'd0);
    repeat (3) step('0, 1'b1);
    repeat (2) step('0, 1'b0);
    send_symbol(4'hB);
    send_symbol(4'h4);

    // randomized stream with jitter, noise, silent stretches and occasional resets
    gen_phase   = 0;
    silent_left = 0;
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r == 97) begin
        step('0, 1'b1);
      end else begin
        if (silent_left > 0) begin
          s = '0;
          silent_left--;
        end else if (gen_phase == 0) begin
          s = WIDTH'($urandom_range(0, 15));
        end else begin
          s = (r < 3) ? WIDTH'($urandom_range(1, 15)) : '0;
        end
        if (r == 99) silent_left = FACTOR * int'($urandom_range(3, 6));
        step(s, 1'b0);
      end
      gen_phase = (gen_phase + 1) % FACTOR;
    end

    // continuous off-phase energy: a realign every cycle, saturates the counter
    repeat (310) step(4'hF, 1'b0);
    repeat (FACTOR * 6) step('0, 1'b0);

    @(posedge clk);
    #2;
    check("strobe_queue_drained", 32'(st_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
